// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: PC, async-read instruction memory, two-word (LDM/LDD/STD) assembly, registered issue slot.
// Optional macro RESET_VECTOR_FROM_MEM_EN: load the start PC from memory word 0 after reset.
module fetch_issue_unit #(
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [15:0]       im_rdata,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_target,
   output logic              out_valid,
   output logic [8:0]        out_opcode,
   output logic [2:0]        out_rsrc,
   output logic [2:0]        out_rdst,
   output logic [15:0]       out_imm,
   output logic [ADDR_W-1:0] out_pc_next
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_IMM
`ifdef RESET_VECTOR_FROM_MEM_EN
      , S_VEC
`endif
   } state_t;

`ifdef RESET_VECTOR_FROM_MEM_EN
   localparam state_t RESET_STATE = S_VEC;
`else
   localparam state_t RESET_STATE = S_FETCH;
`endif

   localparam logic [8:0] OP_LDM = 9'b011_000010;
   localparam logic [8:0] OP_LDD = 9'b011_000011;
   localparam logic [8:0] OP_STD = 9'b011_000100;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, pc_inc;
   logic [8:0]        hold_op, hold_op_nx;
   logic [2:0]        hold_rs, hold_rs_nx, hold_rd, hold_rd_nx;
   logic              valid_nx;
   logic [8:0]        opcode_nx;
   logic [2:0]        rsrc_nx, rdst_nx;
   logic [15:0]       imm_nx;
   logic [ADDR_W-1:0] pc_next_nx;
   logic [8:0]        word_op;
   logic [2:0]        word_rs, word_rd;
   logic              word_two;
   logic              unused_bit0;

   assign word_op     = im_rdata[15:7];
   assign word_rs     = im_rdata[6:4];
   assign word_rd     = im_rdata[3:1];
   assign unused_bit0 = im_rdata[0];
   assign word_two    = (word_op == OP_LDM) || (word_op == OP_LDD) || (word_op == OP_STD);
   assign pc_inc      = pc + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RESET_STATE;
         pc          <= RESET_PC;
         hold_op     <= '0;
         hold_rs     <= '0;
         hold_rd     <= '0;
         out_valid   <= 1'b0;
         out_opcode  <= '0;
         out_rsrc    <= '0;
         out_rdst    <= '0;
         out_imm     <= '0;
         out_pc_next <= '0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         hold_op     <= hold_op_nx;
         hold_rs     <= hold_rs_nx;
         hold_rd     <= hold_rd_nx;
         out_valid   <= valid_nx;
         out_opcode  <= opcode_nx;
         out_rsrc    <= rsrc_nx;
         out_rdst    <= rdst_nx;
         out_imm     <= imm_nx;
         out_pc_next <= pc_next_nx;
      end
   end

   // Everything holds by default, which is exactly the stall behaviour.
   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      hold_op_nx = hold_op;
      hold_rs_nx = hold_rs;
      hold_rd_nx = hold_rd;
      valid_nx   = out_valid;
      opcode_nx  = out_opcode;
      rsrc_nx    = out_rsrc;
      rdst_nx    = out_rdst;
      imm_nx     = out_imm;
      pc_next_nx = out_pc_next;
      im_addr    = pc;
`ifdef RESET_VECTOR_FROM_MEM_EN
      if (state == S_VEC) begin
         im_addr = '0;
      end
`endif
      if (flush) begin
         pc_nx     = flush_target;
         state_nx  = S_FETCH;
         valid_nx  = 1'b0;
         opcode_nx = '0;
         imm_nx    = '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (!stall) begin
                  pc_nx   = pc_inc;
                  rsrc_nx = word_rs;
                  rdst_nx = word_rd;
                  if (word_two) begin
                     hold_op_nx = word_op;
                     hold_rs_nx = word_rs;
                     hold_rd_nx = word_rd;
                     valid_nx   = 1'b0;
                     opcode_nx  = '0;
                     imm_nx     = '0;
                     state_nx   = S_IMM;
                  end else begin
                     valid_nx   = 1'b1;
                     opcode_nx  = word_op;
                     imm_nx     = '0;
                     pc_next_nx = pc_inc;
                  end
               end
            end
            S_IMM: begin
               if (!stall) begin
                  valid_nx   = 1'b1;
                  opcode_nx  = hold_op;
                  rsrc_nx    = hold_rs;
                  rdst_nx    = hold_rd;
                  imm_nx     = im_rdata;
                  pc_next_nx = pc_inc;
                  pc_nx      = pc_inc;
                  state_nx   = S_FETCH;
               end
            end
`ifdef RESET_VECTOR_FROM_MEM_EN
            // Stall is deliberately ignored while picking up the start vector.
            S_VEC: begin
               pc_nx     = ADDR_W'(im_rdata);
               valid_nx  = 1'b0;
               opcode_nx = '0;
               state_nx  = S_FETCH;
            end
`endif
            default: begin
               state_nx = S_FETCH;
            end
         endcase
      end
   end

endmodule
